// File: rtl/bit_serializer.sv
// Parallel-to-serial stimulus stage: streams WIDTH-bit words onto X, one bit per CLK.
// Latency: first bit on X one cycle after the accepting edge; words run back-to-back with no gap.
// Backpressure: DIN_READY only in IDLE or on the final bit of a word. Optional parity bit: BIT_SERIALIZER_PARITY_EN.
module bit_serializer #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] DIN,
  input  logic             DIN_VALID,
  output logic             DIN_READY,
  output logic             X,
  output logic             X_VALID,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             last_data;
  logic             cur_bit;
  logic [WIDTH-1:0] shifted;
  logic             take;
  logic             load;
`ifdef BIT_SERIALIZER_PARITY_EN
  logic             par, par_nxt;
`endif

  // Bit currently presented on X and the register contents after it is consumed.
  assign cur_bit   = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
  assign shifted   = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
  assign last_data = (state == S_SHIFT) && (cnt == CW'(WIDTH - 1));

  // Outputs decode straight from registered state, so X and friends never see DIN combinationally.
  assign X_VALID = (state != S_IDLE);
  assign BUSY    = (state != S_IDLE);
`ifdef BIT_SERIALIZER_PARITY_EN
  assign X         = (state == S_SHIFT) ? cur_bit : (state == S_PARITY) ? par : IDLE_LEVEL;
  assign DONE      = (state == S_PARITY);
  assign DIN_READY = (state == S_IDLE) || (state == S_PARITY);
`else
  assign X         = (state == S_SHIFT) ? cur_bit : IDLE_LEVEL;
  assign DONE      = last_data;
  assign DIN_READY = (state == S_IDLE) || last_data;
`endif

  assign take = DIN_VALID && DIN_READY;

  // State register and datapath; reset aborts any word in flight.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= S_IDLE;
      shreg <= '0;
      cnt   <= '0;
`ifdef BIT_SERIALIZER_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      cnt   <= cnt_nxt;
`ifdef BIT_SERIALIZER_PARITY_EN
      par   <= par_nxt;
`endif
    end
  end

  // Next-state logic: shift until the final bit, then reload (zero gap) or fall back to IDLE.
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    load      = 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
    par_nxt   = par;
`endif
    case (state)
      S_IDLE: begin
        load = take;
      end
      S_SHIFT: begin
        if (!last_data) begin
          shreg_nxt = shifted;
          cnt_nxt   = cnt + 1'b1;
        end else begin
`ifdef BIT_SERIALIZER_PARITY_EN
          state_nxt = S_PARITY;
`else
          load      = take;
          state_nxt = S_IDLE;
`endif
        end
      end
`ifdef BIT_SERIALIZER_PARITY_EN
      S_PARITY: begin
        load      = take;
        state_nxt = S_IDLE;
      end
`endif
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    if (load) begin
      state_nxt = S_SHIFT;
      shreg_nxt = DIN;
      cnt_nxt   = '0;
`ifdef BIT_SERIALIZER_PARITY_EN
      par_nxt   = ^DIN;
`endif
    end
  end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Upstream stimulus stage for the Moore sequence detector: converts parallel words into the single-bit serial stream driven onto the detector's X input, one bit per CLK.
- Accepts words over a valid/ready handshake and streams back-to-back words with no idle gap, so detector patterns spanning word boundaries are preserved.
- Holds X at a fixed idle level when no data is pending.

Parameters:
- WIDTH, 8, bits per parallel word (legal range 2..32).
- MSB_FIRST, 1, 1 = shift out DIN[WIDTH-1] first; 0 = DIN[0] first.
- IDLE_LEVEL, 0, value driven on X while not shifting.

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- RESET  input  1  synchronous, active-high reset, sampled on rising CLK.
- DIN  input  WIDTH  parallel word to serialize.
- DIN_VALID  input  1  DIN holds a valid word.
- DIN_READY  output  1  block accepts DIN this cycle.
- X  output  1  serial bit to the detector, registered.
- X_VALID  output  1  X carries a data (or parity) bit this cycle.
- BUSY  output  1  a word is being shifted out.
- DONE  output  1  one-cycle pulse in the cycle the last bit of a word is on X.

Behaviour:
- Reset (RESET=1 at rising CLK): state=IDLE, X=IDLE_LEVEL, X_VALID=0, BUSY=0, DONE=0, bit counter=0, shift register=0. DIN_READY=1 in the first cycle after reset. Reset applied mid-word aborts the word; the remaining bits are discarded.
- Handshake: transfer occurs on a rising edge with DIN_VALID=1 and DIN_READY=1. DIN is ignored otherwise. DIN_VALID may drop without a transfer; no state is held for it.
- DIN_READY is combinational from state only: 1 in IDLE, and 1 in the cycle the final bit is on X (last SHIFT bit, or PARITY when enabled). 0 otherwise.
- States:
  - IDLE: X=IDLE_LEVEL, X_VALID=0. On transfer -> SHIFT. Capture DIN into the shift register, counter=0.
  - SHIFT: X = current bit (per MSB_FIRST), X_VALID=1, BUSY=1. Counter increments each cycle. At counter=WIDTH-1 this is the last bit: DONE=1.
    - Transfer in the same cycle: reload, and the next cycle is bit 0 of the new word, still in SHIFT (zero-gap).
    - No transfer: -> IDLE.
- Latency: first bit appears on X exactly 1 cycle after the accepting edge. A word occupies exactly WIDTH consecutive cycles of X_VALID=1.
- Counter width: clog2(WIDTH). No wrap beyond WIDTH-1. The counter resets to 0 on every load.
- DONE and the last bit are coincident. DONE never asserts in IDLE.
- Changes to DIN after acceptance have no effect on the word in flight.

Optional Feature:
- Macro: BIT_SERIALIZER_PARITY_EN.
- Defined:
  - After the last data bit, add state PARITY for one cycle. X = even parity (XOR of the captured word), X_VALID=1, BUSY=1.
  - DONE and the DIN_READY window move to the PARITY cycle.
  - A word occupies WIDTH+1 cycles.
- Undefined: no PARITY state. Behaviour is exactly as above.

Test Plan:
- Reset then idle: RESET=1 for 2 cycles, DIN_VALID=0 -> X=0, X_VALID=0, BUSY=0, DONE=0, DIN_READY=1 for 10 cycles.
- Single word, WIDTH=8, MSB_FIRST=1:
  - Stimulus: DIN=8'b1001_1001 accepted at edge N.
  - Response: X=1,0,0,1,1,0,0,1 on cycles N+1..N+8; X_VALID=1 for exactly those cycles; DONE only at N+8; DIN_READY=0 at N+1..N+7 and 1 at N+8; IDLE at N+9.
- Back-to-back: DIN_VALID held high with words 8'hA5 then 8'h3C -> 16 consecutive X_VALID cycles reading 1010_0101_0011_1100, with no idle bit between words.
- LSB-first: MSB_FIRST=0, DIN=8'h01 -> X=1 then seven 0s.
- Reset mid-word: RESET at the 4th bit of 8'hFF -> next cycle X=0, X_VALID=0, DIN_READY=1; the new word 8'h0F then shifts cleanly from bit 0.
- Parity (macro defined): DIN=8'h07 -> 8 data bits, then X=1 on the 9th cycle with DONE=1; DIN=8'h03 -> 9th bit 0.
